bch_rx_deserializer: RTL and testbench

Bit-serial receive front end for the BCH(15,7,2) decoder path. It collects a framed serial bit stream into 15-bit received words and buffers them in a small FIFO. It presents each word on a valid/ready interface to the combinational syndrome/locator/Chien decode stage, which consumes the 15-bit `received_poly`. Optionally, it computes the generator-polynomial remainder on the fly, so each word carries an early error flag.

---
 rtl/bch_pkg.sv | 14 +
 rtl/bch_word_fifo.sv | 58 +++++
 rtl/bch_rx_deserializer.sv | 136 +++++++++++++
 tb/tb_bch_rx_deserializer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/bch_pkg.sv
// Shared BCH(15,7,2) constants and receive-FSM state type.
// Referenced by the deserializer, encoder and error-finder.
package bch_pkg;

    localparam int unsigned BCH_N        = 15;
    localparam int unsigned BCH_K        = 7;
    localparam logic [8:0]  BCH_GEN_POLY = 9'b111010001;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } rx_state_t;

endpackage

// File: rtl/bch_word_fifo.sv
// Small synchronous FIFO for received words; push and pop may coincide when full.
// Head data reads as zero while empty so the output is defined out of reset.
module bch_word_fifo #(
    parameter int unsigned W     = 15,
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0] mem_q [DEPTH];
    logic [W-1:0] mem_d [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         push_ok;
    logic         pop_ok;

    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d                = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/bch_rx_deserializer.sv
// Serial-to-word receive front end for the BCH(15,7,2) decoder path.
// Optional on-the-fly g(x) remainder check enabled by BCH_RX_SYNDROME_CHECK_EN.
module bch_rx_deserializer
    import bch_pkg::*;
#(
    parameter int unsigned N        = BCH_N,
    parameter logic [8:0]  GEN_POLY = BCH_GEN_POLY,
    parameter int unsigned DEPTH    = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ser_valid,
    input  logic         ser_bit,
    input  logic         ser_sof,
    output logic         word_valid,
    input  logic         word_ready,
    output logic [N-1:0] word_data,
`ifdef BCH_RX_SYNDROME_CHECK_EN
    output logic         word_err,
`endif
    output logic         frame_err,
    output logic         overrun
);

`ifdef BCH_RX_SYNDROME_CHECK_EN
    localparam int unsigned FW = N + 1;
`else
    localparam int unsigned FW = N;
`endif

    rx_state_t     state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [N-1:0]  shreg_q, shreg_d;
    logic          frame_err_q, frame_err_d;
    logic          overrun_q, overrun_d;
    logic          push;
    logic [FW-1:0] push_data;
    logic [FW-1:0] pop_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic          pop;

`ifdef BCH_RX_SYNDROME_CHECK_EN
    logic [7:0] rem_q, rem_d, rem_next;
    assign rem_next = {rem_q[6:0], ser_bit} ^ (rem_q[7] ? GEN_POLY[7:0] : 8'b0);
`endif

    assign pop = word_ready && !fifo_empty;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shreg_d     = shreg_q;
        frame_err_d = 1'b0;
        overrun_d   = overrun_q;
        push        = 1'b0;
`ifdef BCH_RX_SYNDROME_CHECK_EN
        rem_d       = rem_q;
        push_data   = {(rem_next != 8'b0), shreg_q[N-2:0], ser_bit};
`else
        push_data   = {shreg_q[N-2:0], ser_bit};
`endif
        if (ser_valid) begin
            // A start-of-frame beat always restarts collection; in SHIFT it also aborts.
            if (ser_sof) begin
                frame_err_d = (state_q == SHIFT);
                state_d     = SHIFT;
                cnt_d       = 4'd1;
                shreg_d     = {{(N-1){1'b0}}, ser_bit};
`ifdef BCH_RX_SYNDROME_CHECK_EN
                rem_d       = {7'b0, ser_bit};
`endif
            end else if (state_q == SHIFT) begin
                shreg_d = {shreg_q[N-2:0], ser_bit};
`ifdef BCH_RX_SYNDROME_CHECK_EN
                rem_d   = rem_next;
`endif
                if (cnt_q == 4'(N - 1)) begin
                    push    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = 4'd0;
                    if (fifo_full && !pop) begin
                        overrun_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            shreg_q     <= '0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
`ifdef BCH_RX_SYNDROME_CHECK_EN
            rem_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shreg_q     <= shreg_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
`ifdef BCH_RX_SYNDROME_CHECK_EN
            rem_q       <= rem_d;
`endif
        end
    end

    bch_word_fifo #(
        .W     (FW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (word_ready),
        .pop_data  (pop_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign word_valid = !fifo_empty;
    assign word_data  = pop_data[N-1:0];
`ifdef BCH_RX_SYNDROME_CHECK_EN
    assign word_err   = pop_data[N];
`endif
    assign frame_err  = frame_err_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_bch_rx_deserializer.sv
// Directed self-checking bench for bch_rx_deserializer.
// Covers reset, clean/corrupt words, gaps, abort, backpressure and full-with-pop.
module tb_bch_rx_deserializer;

    logic        clk = 1'b0;
    logic        rst;
    logic        ser_valid;
    logic        ser_bit;
    logic        ser_sof;
    logic        word_valid;
    logic        word_ready;
    logic [14:0] word_data;
    logic        word_err;
    logic        frame_err;
    logic        overrun;
    int          checks = 0;
    int          errors = 0;
    int          fe_count;

    always #5 clk = ~clk;

    bch_rx_deserializer #(
        .N        (15),
        .GEN_POLY (9'b111010001),
        .DEPTH    (2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ser_valid  (ser_valid),
        .ser_bit    (ser_bit),
        .ser_sof    (ser_sof),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .word_data  (word_data),
`ifdef BCH_RX_SYNDROME_CHECK_EN
        .word_err   (word_err),
`endif
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

`ifndef BCH_RX_SYNDROME_CHECK_EN
    assign word_err = 1'b0;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One qualified beat; outputs are then sampled 1ns after the capturing edge.
    task automatic beat(input logic b, input logic sof, input logic pop);
        @(negedge clk);
        ser_valid  = 1'b1;
        ser_bit    = b;
        ser_sof    = sof;
        word_ready = pop;
        @(posedge clk);
        #1;
        ser_valid  = 1'b0;
        word_ready = 1'b0;
        if (frame_err) fe_count++;
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (frame_err) fe_count++;
        end
    endtask

    task automatic send_word(input logic [14:0] w, input int unsigned max_gap, input logic pop_last);
        for (int i = 14; i >= 0; i--) begin
            beat(w[i], i == 14, (i == 0) ? pop_last : 1'b0);
            if (max_gap != 0 && i != 0) idle($urandom_range(max_gap, 1));
        end
    endtask

    task automatic pop_word;
        @(negedge clk);
        word_ready = 1'b1;
        @(posedge clk);
        #1;
        word_ready = 1'b0;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ser_valid = 1'($urandom);
            ser_bit   = 1'($urandom);
            ser_sof   = 1'($urandom);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        rst       = 1'b0;
        ser_valid = 1'b0;
        ser_sof   = 1'b0;
    endtask

    initial begin
        rst        = 1'b0;
        ser_valid  = 1'b0;
        ser_bit    = 1'b0;
        ser_sof    = 1'b0;
        word_ready = 1'b0;
        fe_count   = 0;

        // Reset with random serial activity
        do_reset();
        check("rst_valid", 32'(word_valid), 32'h0);
        check("rst_data", 32'(word_data), 32'h0);
        check("rst_err", 32'(word_err), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        idle(1);
        check("post_rst_valid_1", 32'(word_valid), 32'h0);
        idle(1);
        check("post_rst_valid_2", 32'(word_valid), 32'h0);

        // Clean codeword g(x)
        send_word(15'h01D1, 0, 1'b0);
        check("clean_valid", 32'(word_valid), 32'h1);
        check("clean_data", 32'(word_data), 32'h01D1);
        check("clean_err", 32'(word_err), 32'h0);
        pop_word();
        check("clean_drained", 32'(word_valid), 32'h0);

        // Single-bit error, then all-zero word
        send_word(15'h01D0, 0, 1'b0);
        check("sbe_data", 32'(word_data), 32'h01D0);
`ifdef BCH_RX_SYNDROME_CHECK_EN
        check("sbe_err", 32'(word_err), 32'h1);
`endif
        pop_word();
        send_word(15'h0000, 0, 1'b0);
        check("zero_valid", 32'(word_valid), 32'h1);
        check("zero_data", 32'(word_data), 32'h0000);
        check("zero_err", 32'(word_err), 32'h0);
        pop_word();

        // Gaps between beats
        send_word(15'h4ABC, 3, 1'b0);
        check("gap_data", 32'(word_data), 32'h4ABC);
        pop_word();
        check("gap_drained", 32'(word_valid), 32'h0);

        // Abort: sof again on the 8th beat, which begins 01D1
        fe_count = 0;
        for (int i = 0; i < 7; i++) beat(1'b1, i == 0, 1'b0);
        check("abort_fe_before", 32'(frame_err), 32'h0);
        send_word(15'h01D1, 0, 1'b0);
        check("abort_fe_count", 32'(fe_count), 32'h1);
        check("abort_data", 32'(word_data), 32'h01D1);
        pop_word();
        check("abort_single_word", 32'(word_valid), 32'h0);
        beat(1'b1, 1'b1, 1'b0);
        beat(1'b0, 1'b1, 1'b0);
        check("abort_pulse_hi", 32'(frame_err), 32'h1);
        idle(1);
        check("abort_pulse_lo", 32'(frame_err), 32'h0);

        // Backpressure and overrun
        do_reset();
        send_word(15'h0001, 0, 1'b0);
        send_word(15'h0002, 0, 1'b0);
        check("bp_overrun_pre", 32'(overrun), 32'h0);
        send_word(15'h0003, 0, 1'b0);
        check("bp_overrun", 32'(overrun), 32'h1);
        check("bp_head_stable", 32'(word_data), 32'h0001);
        pop_word();
        check("bp_second", 32'(word_data), 32'h0002);
        pop_word();
        check("bp_drained", 32'(word_valid), 32'h0);
        check("bp_overrun_sticky", 32'(overrun), 32'h1);

        // Full FIFO with simultaneous pop accepts the new word
        do_reset();
        check("rst_clears_overrun", 32'(overrun), 32'h0);
        send_word(15'h1111, 0, 1'b0);
        send_word(15'h2222, 0, 1'b0);
        send_word(15'h3333, 0, 1'b1);
        check("fullpop_overrun", 32'(overrun), 32'h0);
        check("fullpop_head", 32'(word_data), 32'h2222);
        pop_word();
        check("fullpop_tail", 32'(word_data), 32'h3333);
        pop_word();
        check("fullpop_drained", 32'(word_valid), 32'h0);

        // Back-to-back frames without dead cycles
        send_word(15'h5555, 0, 1'b0);
        send_word(15'h2AAA, 0, 1'b0);
        check("b2b_first", 32'(word_data), 32'h5555);
        pop_word();
        check("b2b_second", 32'(word_data), 32'h2AAA);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
